// File: rtl/tl_phase_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_pkg
// Brief    : Shared types, lamp encodings and display helpers for the
//            traffic-light phase timer.
// Revision : 1.0 - initial release
// ============================================================================
package tl_pkg;

    // Phase order around the junction; the sequencer steps through these in order.
    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } phase_e;

    // Lamp encodings, bit order {red, yellow, green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Widest counter the BCD helper accepts; callers zero-extend into it.
    localparam int BCD_IN_W = 32;

    // Two BCD digits {tens, ones}; anything above 99 shows as 99.
    function automatic logic [7:0] bin2bcd_sat(input logic [BCD_IN_W-1:0] value);
        logic [6:0] v;
        logic [3:0] tens;
        logic [3:0] ones;
        v    = (value > BCD_IN_W'(99)) ? 7'd99 : value[6:0];
        tens = 4'(v / 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

    // North-south lamp pattern for a phase.
    function automatic logic [2:0] lamp_ns(input phase_e p);
        case (p)
            NS_GREEN:  return LAMP_GRN;
            NS_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

    // East-west lamp pattern for a phase.
    function automatic logic [2:0] lamp_ew(input phase_e p);
        case (p)
            EW_GREEN:  return LAMP_GRN;
            EW_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_phase_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : tl_phase_timer_if
// Brief    : Control / status bundle of the phase timer. The controller side
//            uses the master modport, the timer uses the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface tl_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             night;
    logic             cfg_we;
    logic [CNT_W-1:0] cfg_green;
    logic [CNT_W-1:0] cfg_yellow;
    logic             tick;
    logic [1:0]       phase;
    logic             phase_done;
    logic [CNT_W-1:0] remain;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic [2:0]       light_ns;
    logic [2:0]       light_ew;

    modport master (
        output en, night, cfg_we, cfg_green, cfg_yellow,
        input  tick, phase, phase_done, remain, bcd_tens, bcd_ones, light_ns, light_ew
    );

    modport slave (
        input  en, night, cfg_we, cfg_green, cfg_yellow,
        output tick, phase, phase_done, remain, bcd_tens, bcd_ones, light_ns, light_ew
    );
endinterface
`default_nettype wire

// File: rtl/tl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tl_tick_gen
// Brief    : Divide-by-CLK_DIV prescaler with enable and synchronous clear.
//            o_tick is high for the whole cycle in which the count sits at
//            CLK_DIV-1 while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module tl_tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,
    input  wire logic i_clr,
    output logic      o_tick
);

    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Prescaler count: clear wins over enable, wraps after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    assign o_tick = i_en & ~i_clr & (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/tl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tl_phase_timer
// Brief    : Two-direction traffic-light phase sequencer with one-second
//            prescaler, loadable phase durations, pause and flashing-amber
//            night mode. Remaining time is shown in binary and BCD.
// Revision : 1.0 - initial release
// ============================================================================
module tl_phase_timer
    import tl_pkg::*;
#(
    parameter int CLK_DIV  = 50_000_000,
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 30,
    parameter int T_YELLOW = 5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    tl_phase_timer_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_RST_GREEN  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] c_RST_YELLOW = CNT_W'(T_YELLOW);

    // A zero duration would stall the countdown, so it is run as one tick.
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    phase_e           r_phase;
    logic [CNT_W-1:0] r_remain;
    logic             r_phase_done;
    logic [2:0]       r_light_ns;
    logic [2:0]       r_light_ew;
    logic             r_flash;
    logic             r_night_d;
    logic [CNT_W-1:0] r_shadow_green;
    logic [CNT_W-1:0] r_shadow_yellow;

    phase_e           w_phase_nxt;
    phase_e           w_phase_adv;
    logic [CNT_W-1:0] w_remain_nxt;
    logic             w_done_nxt;
    logic [2:0]       w_light_ns_nxt;
    logic [2:0]       w_light_ew_nxt;
    logic             w_flash_nxt;
    logic             w_run;
    logic             w_night_exit;
    logic             w_phase_tick;
    logic             w_flash_tick;
    logic [7:0]       w_bcd;

    assign w_run        = bus.en & ~bus.night;
    assign w_night_exit = ~bus.night & r_night_d;

    // Phase prescaler: parked at zero through night and the exit cycle so the
    // first normal tick lands a full period after the exit edge.
    tl_tick_gen #(.CLK_DIV(CLK_DIV)) u_phase_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_run),
        .i_clr  (bus.night | r_night_d),
        .o_tick (w_phase_tick)
    );

    // Flash prescaler: runs only in night mode, otherwise held cleared.
    tl_tick_gen #(.CLK_DIV(CLK_DIV)) u_flash_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (bus.night),
        .i_clr  (~bus.night),
        .o_tick (w_flash_tick)
    );

    // Shadow durations; the running countdown is never touched here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_green  <= c_RST_GREEN;
            r_shadow_yellow <= c_RST_YELLOW;
        end else if (bus.cfg_we) begin
            r_shadow_green  <= bus.cfg_green;
            r_shadow_yellow <= bus.cfg_yellow;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= NS_GREEN;
            r_remain     <= c_RST_GREEN;
            r_phase_done <= 1'b0;
            r_light_ns   <= LAMP_GRN;
            r_light_ew   <= LAMP_RED;
            r_flash      <= 1'b0;
            r_night_d    <= 1'b0;
        end else begin
            r_phase      <= w_phase_nxt;
            r_remain     <= w_remain_nxt;
            r_phase_done <= w_done_nxt;
            r_light_ns   <= w_light_ns_nxt;
            r_light_ew   <= w_light_ew_nxt;
            r_flash      <= w_flash_nxt;
            r_night_d    <= bus.night;
        end
    end

    // Next-state: night overrides everything, then night exit, then ticks.
    // Reloads read the shadow registers before any coincident cfg_we lands.
    always_comb begin
        w_phase_nxt    = r_phase;
        w_remain_nxt   = r_remain;
        w_done_nxt     = 1'b0;
        w_light_ns_nxt = r_light_ns;
        w_light_ew_nxt = r_light_ew;
        w_flash_nxt    = 1'b0;
        w_phase_adv    = phase_e'(r_phase + 2'd1);

        if (bus.night) begin
            w_flash_nxt    = r_flash ^ w_flash_tick;
            w_remain_nxt   = '0;
            w_light_ns_nxt = {1'b0, w_flash_nxt, 1'b0};
            w_light_ew_nxt = {1'b0, w_flash_nxt, 1'b0};
        end else if (w_night_exit) begin
            w_phase_nxt    = NS_GREEN;
            w_remain_nxt   = f_load(r_shadow_green);
            w_light_ns_nxt = lamp_ns(NS_GREEN);
            w_light_ew_nxt = lamp_ew(NS_GREEN);
        end else if (w_phase_tick) begin
            if (r_remain > CNT_W'(1)) begin
                w_remain_nxt = r_remain - CNT_W'(1);
            end else begin
                w_phase_nxt    = w_phase_adv;
                w_done_nxt     = 1'b1;
                w_light_ns_nxt = lamp_ns(w_phase_adv);
                w_light_ew_nxt = lamp_ew(w_phase_adv);
                if ((w_phase_adv == NS_GREEN) || (w_phase_adv == EW_GREEN)) begin
                    w_remain_nxt = f_load(r_shadow_green);
                end else begin
                    w_remain_nxt = f_load(r_shadow_yellow);
                end
            end
        end
    end

    assign w_bcd = bin2bcd_sat(BCD_IN_W'(r_remain));

    assign bus.tick       = w_phase_tick | w_flash_tick;
    assign bus.phase      = r_phase;
    assign bus.phase_done = r_phase_done;
    assign bus.remain     = r_remain;
    assign bus.bcd_tens   = w_bcd[7:4];
    assign bus.bcd_ones   = w_bcd[3:0];
    assign bus.light_ns   = r_light_ns;
    assign bus.light_ew   = r_light_ew;

endmodule
`default_nettype wire

// File: tb/tb_tl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_phase_timer
// Brief    : Directed self-checking bench for tl_phase_timer with
//            CLK_DIV=4, CNT_W=8, T_GREEN=3, T_YELLOW=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_phase_timer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n_tick;
    int   n_done;

    tl_phase_timer_if #(.CNT_W(8)) bus ();

    tl_phase_timer #(
        .CLK_DIV  (4),
        .CNT_W    (8),
        .T_GREEN  (3),
        .T_YELLOW (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, counting tick and phase_done pulses seen.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1)       n_tick++;
            if (bus.phase_done === 1'b1) n_done++;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        n_tick     = 0;
        n_done     = 0;
        rst_n      = 1'b0;
        bus.en     = 1'b1;
        bus.night  = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_green  = 8'd0;
        bus.cfg_yellow = 8'd0;

        // Reset state
        run(2);
        chk("rst_phase", bus.phase, 0);
        chk("rst_remain", bus.remain, 3);
        chk("rst_bcd_t", bus.bcd_tens, 0);
        chk("rst_bcd_o", bus.bcd_ones, 3);
        chk("rst_ns", bus.light_ns, 3'b001);
        chk("rst_ew", bus.light_ew, 3'b100);
        chk("rst_tick", bus.tick, 0);
        chk("rst_done", bus.phase_done, 0);

        // Free run: k counts clocks since release
        rst_n  = 1'b1;
        n_tick = 0;
        n_done = 0;
        run(2);                                   // k=2
        chk("k2_tick", bus.tick, 0);
        run(1);                                   // k=3
        chk("first_tick", bus.tick, 1);
        chk("k3_remain", bus.remain, 3);
        run(1);                                   // k=4
        chk("k4_remain", bus.remain, 2);
        chk("k4_tick", bus.tick, 0);
        run(7);                                   // k=11
        chk("k11_phase", bus.phase, 0);
        chk("k11_remain", bus.remain, 1);
        run(1);                                   // k=12
        chk("k12_phase", bus.phase, 1);
        chk("k12_remain", bus.remain, 2);
        chk("k12_done", bus.phase_done, 1);
        chk("k12_ns", bus.light_ns, 3'b010);
        chk("k12_ew", bus.light_ew, 3'b100);
        run(1);                                   // k=13
        chk("k13_done", bus.phase_done, 0);
        run(7);                                   // k=20
        chk("k20_phase", bus.phase, 2);
        chk("k20_remain", bus.remain, 3);
        chk("k20_ns", bus.light_ns, 3'b100);
        chk("k20_ew", bus.light_ew, 3'b001);
        run(12);                                  // k=32
        chk("k32_phase", bus.phase, 3);
        chk("k32_remain", bus.remain, 2);
        chk("k32_ns", bus.light_ns, 3'b100);
        chk("k32_ew", bus.light_ew, 3'b010);
        run(8);                                   // k=40
        chk("k40_phase", bus.phase, 0);
        chk("k40_remain", bus.remain, 3);
        chk("k40_done", bus.phase_done, 1);
        chk("free_ticks", n_tick, 10);
        chk("free_dones", n_done, 4);

        // Pause at remain 2 with the prescaler at count 2
        run(6);                                   // k=46
        chk("pre_pause_remain", bus.remain, 2);
        bus.en = 1'b0;
        n_tick = 0;
        run(10);
        chk("pause_ticks", n_tick, 0);
        chk("pause_remain", bus.remain, 2);
        chk("pause_phase", bus.phase, 0);
        bus.en = 1'b1;
        chk("resume_j0_tick", bus.tick, 0);
        run(1);
        chk("resume_j1_tick", bus.tick, 1);
        chk("resume_j1_remain", bus.remain, 2);
        run(1);
        chk("resume_j2_remain", bus.remain, 1);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_remain", bus.remain, 3);
        chk("arst_phase", bus.phase, 0);
        chk("arst_ns", bus.light_ns, 3'b001);
        chk("arst_ew", bus.light_ew, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;                             // k=0

        // New shadow durations during phase 0
        bus.cfg_we     = 1'b1;
        bus.cfg_green  = 8'd12;
        bus.cfg_yellow = 8'd0;
        run(1);                                   // k=1
        bus.cfg_we = 1'b0;
        chk("cfg_remain_kept", bus.remain, 3);
        run(10);                                  // k=11
        chk("cfg_k11_phase", bus.phase, 0);
        chk("cfg_k11_remain", bus.remain, 1);
        run(1);                                   // k=12
        chk("cfg_y0_phase", bus.phase, 1);
        chk("cfg_y0_remain", bus.remain, 1);
        run(4);                                   // k=16
        chk("cfg_g12_phase", bus.phase, 2);
        chk("cfg_g12_remain", bus.remain, 12);
        chk("cfg_g12_bcd_t", bus.bcd_tens, 1);
        chk("cfg_g12_bcd_o", bus.bcd_ones, 2);
        run(51);                                  // k=67
        chk("k67_phase", bus.phase, 3);
        chk("k67_tick", bus.tick, 1);
        chk("k67_remain", bus.remain, 1);

        // cfg_we on the advance tick: reload uses the old green value
        bus.cfg_we     = 1'b1;
        bus.cfg_green  = 8'd120;
        bus.cfg_yellow = 8'd2;
        run(1);                                   // k=68
        bus.cfg_we = 1'b0;
        chk("coinc_phase", bus.phase, 0);
        chk("coinc_remain", bus.remain, 12);
        chk("coinc_done", bus.phase_done, 1);

        // Night mode entered mid-phase
        run(2);                                   // k=70
        bus.night = 1'b1;
        run(1);                                   // n=1
        chk("n1_remain", bus.remain, 0);
        chk("n1_ns", bus.light_ns, 3'b000);
        chk("n1_ew", bus.light_ew, 3'b000);
        chk("n1_bcd_o", bus.bcd_ones, 0);
        chk("n1_done", bus.phase_done, 0);
        run(2);                                   // n=3
        chk("n3_tick", bus.tick, 1);
        run(1);                                   // n=4
        chk("n4_ns", bus.light_ns, 3'b010);
        chk("n4_ew", bus.light_ew, 3'b010);
        run(4);                                   // n=8
        chk("n8_ns", bus.light_ns, 3'b000);
        run(4);                                   // n=12
        chk("n12_ew", bus.light_ew, 3'b010);
        chk("n12_remain", bus.remain, 0);
        run(1);                                   // n=13

        // Night exit loads shadow green (120) and shows saturated BCD
        bus.night = 1'b0;                         // m=0
        run(1);                                   // m=1
        chk("exit_phase", bus.phase, 0);
        chk("exit_remain", bus.remain, 120);
        chk("exit_ns", bus.light_ns, 3'b001);
        chk("exit_ew", bus.light_ew, 3'b100);
        chk("exit_bcd_t", bus.bcd_tens, 9);
        chk("exit_bcd_o", bus.bcd_ones, 9);
        chk("exit_done", bus.phase_done, 0);
        run(2);                                   // m=3
        chk("exit_m3_tick", bus.tick, 0);
        run(1);                                   // m=4
        chk("exit_m4_tick", bus.tick, 1);
        run(1);                                   // m=5
        chk("m5_remain", bus.remain, 119);
        run(76);                                  // m=81
        chk("r100_remain", bus.remain, 100);
        chk("r100_bcd_t", bus.bcd_tens, 9);
        chk("r100_bcd_o", bus.bcd_ones, 9);
        run(4);                                   // m=85
        chk("r99_remain", bus.remain, 99);
        chk("r99_bcd_o", bus.bcd_ones, 9);
        run(4);                                   // m=89
        chk("r98_bcd_t", bus.bcd_tens, 9);
        chk("r98_bcd_o", bus.bcd_ones, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_phase_timer.md
# tl_phase_timer

Parametrised two-direction traffic-light phase sequencer with on-chip one-second prescaler, runtime-loadable phase durations, pause and night (flashing-amber) modes. It drives the north-south and east-west lamp outputs directly and presents the remaining phase time as binary and two-digit BCD for the seven-segment display driver. It replaces the fixed two-period countdown in the signal controller top level.

## Interface
Parameters:
- CLK_DIV, 50_000_000: clk cycles per tick (one second).
- CNT_W, 8: width of duration/remaining counters.
- T_GREEN, 30: reset green duration in ticks.
- T_YELLOW, 5: reset yellow duration in ticks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = run; 0 = freeze prescaler and counter.
- night  in  1  1 = night mode (flashing amber).
- cfg_we  in  1  load cfg_green/cfg_yellow into shadow registers.
- cfg_green  in  CNT_W  new green duration.
- cfg_yellow  in  CNT_W  new yellow duration.
- tick  out  1  one-cycle pulse each tick.
- phase  out  2  0 NS_GREEN, 1 NS_YELLOW, 2 EW_GREEN, 3 EW_YELLOW.
- phase_done  out  1  one-cycle pulse on phase advance.
- remain  out  CNT_W  ticks left in the current phase.
- bcd_tens, bcd_ones  out  4 each  BCD of remain, saturated at 99.
- light_ns, light_ew  out  3 each  {red, yellow, green}.

## Operation
- Reset values: prescaler 0, phase 0, remain T_GREEN, shadow green/yellow = T_GREEN/T_YELLOW, light_ns 001, light_ew 100, tick 0, phase_done 0, flash 0.
- Prescaler counts 0..CLK_DIV-1 while en=1 and night=0. tick is asserted while count==CLK_DIV-1, after which count wraps to 0.
- On tick with remain>1: remain decrements.
- On tick with remain==1: phase advances (3 wraps to 0), remain loads the shadow duration for the new phase, and phase_done pulses.
- Each phase therefore displays T..1 for one tick each.
- Shadow duration value 0 is loaded as 1.
- cfg_we updates the shadow registers only. The running remain is unaffected. New values take effect at the next load of that phase type.
- Lamps by phase: phase 0 NS 001 / EW 100; phase 1 NS 010 / EW 100; phase 2 NS 100 / EW 001; phase 3 NS 100 / EW 010.
- Night mode has priority over en:
  - A separate flash prescaler (same CLK_DIV) keeps running and pulses tick.
  - flash toggles on each tick.
  - Both lamps show {0, flash, 0}. remain = 0. phase_done = 0.
- Night exit (night falls):
  - phase 0, remain = shadow green, prescaler 0, flash 0.
  - Normal lamps appear on the next clock.
- When en=0 in normal mode, all state is held and tick = 0.
- cfg_we coincident with a phase-advance tick: the reload uses the old shadow value.

## Timing
- phase, remain, lamps and phase_done are registered. They update on the clk edge that ends the tick cycle, so there is 1 cycle latency from tick.
- phase_done is high for exactly the cycle following the tick, coincident with the new phase and remain.
- bcd_tens and bcd_ones are combinational from remain (zero added latency).
- The rst_n assertion takes effect asynchronously mid-phase. All outputs take reset values immediately. The first tick occurs CLK_DIV cycles after release.

## Structure
- Package tl_pkg contains:
  - phase enum (NS_GREEN..EW_YELLOW).
  - lamp constants LAMP_RED=100, LAMP_YEL=010, LAMP_GRN=001, LAMP_OFF=000.
  - a bin2bcd_sat function (CNT_W to two BCD digits, saturating at 99).
- Sub-module tl_tick_gen: parametrised CLK_DIV prescaler with enable and synchronous clear, producing tick. It is instantiated twice, once for the phase prescaler and once for the flash prescaler.

## Test plan
Use CLK_DIV=4, T_GREEN=3, T_YELLOW=2 unless stated.
- Reset release -> phase 0, remain 3, bcd 0/3, light_ns 001, light_ew 100; first tick at clock 4.
- Free run for 40 clocks -> phases 0,1,2,3 lasting 12, 8, 12, 8 clocks; phase_done pulses 4 times; back at phase 0 with remain 3.
- en=0 for 10 clocks at remain 2 -> remain, phase and prescaler frozen, no tick; resume gives the next tick exactly at the remaining prescaler count.
- cfg_we with green=12 and yellow=0 during phase 0 -> phase 0 still ends after 3 ticks; phase 1 loads 1; phase 2 loads 12 with bcd 1/2.
- night=1 mid-phase -> lamps 000 then 010 for both directions, toggling every 4 clocks, remain 0; night=0 -> phase 0, remain equals shadow green, prescaler 0.
- CNT_W=8, cfg_green=120 -> remain 120 displays bcd 9/9 until remain ≤ 99; asynchronous rst_n mid-count restores reset values without a clock edge.
